cache_dm_wb_burst: RTL and testbench

//  Parametrised direct-mapped write-back, write-allocate data cache between the CPU load/store

---
 rtl/cache_dm_wb_burst_pkg.sv | 29 ++
 rtl/cache_dm_wb_burst_tag_array.sv | 46 ++++
 rtl/cache_dm_wb_burst.sv | 203 ++++++++++++++++++++
 tb/tb_cache_dm_wb_burst.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_dm_wb_burst_pkg.sv
// Shared definitions for the direct-mapped write-back cache family.
// Holds the FSM state encoding and the address-split width helpers so the
// planned 2-way variant derives its geometry the same way.
package cache_dm_wb_burst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_FILL = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam int WORD_BYTES = 4;

  // byte-offset width inside a line: 2 bits of byte select plus word select
  function automatic int calc_off_w(input int line_words);
    return 2 + $clog2(line_words);
  endfunction

  function automatic int calc_idx_w(input int size_bytes, input int line_words);
    return $clog2(size_bytes / (WORD_BYTES * line_words));
  endfunction

  // beat / word-select register width; kept at least 1 bit for 1-word lines
  function automatic int calc_sel_w(input int line_words);
    return (line_words > 1) ? $clog2(line_words) : 1;
  endfunction

endpackage

// File: rtl/cache_dm_wb_burst_tag_array.sv
// Valid/dirty/tag storage, one read port (combinational) and one write port.
// Ports: rd_idx -> rd_valid/rd_dirty/rd_tag; wr_en/wr_idx/wr_tag/wr_dirty write
// an entry and mark it valid. Reset clears valid and dirty only; tags persist.
module cache_dm_wb_burst_tag_array
  import cache_dm_wb_burst_pkg::*;
#(
  parameter int IDX_W = 9,
  parameter int TAG_W = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic             rd_dirty,
  output logic [TAG_W-1:0] rd_tag,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_dirty
);

  localparam int LINES = 1 << IDX_W;

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAG_W-1:0] tag_q [LINES];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
      dirty_q[wr_idx] <= wr_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) tag_q[wr_idx] <= wr_tag;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];

endmodule

// File: rtl/cache_dm_wb_burst.sv
// Direct-mapped write-back, write-allocate data cache with word-serial bursts.
// CPU side: cpu_req/we/addr/wdata in (sampled in IDLE), cpu_rdata/done/busy out.
// Memory side: mem_req/we/addr/wdata out, mem_rdata/ack in; one word per ack.
module cache_dm_wb_burst
  import cache_dm_wb_burst_pkg::*;
#(
  parameter int SIZE_BYTES = 8192,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int OFF_W = calc_off_w(LINE_WORDS);
  localparam int IDX_W = calc_idx_w(SIZE_BYTES, LINE_WORDS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int SEL_W = calc_sel_w(LINE_WORDS);
  localparam int WSH   = OFF_W - 2;          // log2(LINE_WORDS), may be 0
  localparam int DA_W  = IDX_W + WSH;
  localparam int DEPTH = 1 << DA_W;
  localparam logic [SEL_W-1:0] LAST_BEAT = SEL_W'(LINE_WORDS - 1);

  // word select via shift/mask so 1-word lines need no zero-width slice
  function automatic logic [SEL_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    return SEL_W'((a >> 2) & ADDR_W'(LINE_WORDS - 1));
  endfunction

  function automatic logic [DA_W-1:0] da_of(input logic [IDX_W-1:0] idx,
                                            input logic [SEL_W-1:0] w);
    return (DA_W'(idx) << WSH) | DA_W'(w);
  endfunction

  state_t            state_q, state_d;
  logic              req_we_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [31:0]       req_wdata_q;
  logic [SEL_W-1:0]  beat_q;
  logic              req_on_q;
  logic [31:0]       cpu_rdata_q;
  logic              cpu_done_q;
  logic [31:0]       data_q [DEPTH];

  logic [IDX_W-1:0]  cpu_idx, req_idx, lookup_idx;
  logic [TAG_W-1:0]  cpu_tag, req_tag, tag_rd, beat_tag;
  logic [SEL_W-1:0]  cpu_word, req_word;
  logic              tag_valid, tag_dirty, hit, accept, beat_ack, last_ack;
  logic              tag_wr_en, tag_wr_dirty;
  logic [IDX_W-1:0]  tag_wr_idx;
  logic [TAG_W-1:0]  tag_wr_tag;
  logic              da_wr_en;
  logic [DA_W-1:0]   da_wr_addr;
  logic [31:0]       da_wr_data;
  logic              in_burst;

  assign cpu_idx  = cpu_addr[OFF_W +: IDX_W];
  assign cpu_tag  = cpu_addr[ADDR_W-1 -: TAG_W];
  assign cpu_word = word_of(cpu_addr);
  assign req_idx  = req_addr_q[OFF_W +: IDX_W];
  assign req_tag  = req_addr_q[ADDR_W-1 -: TAG_W];
  assign req_word = word_of(req_addr_q);

  // In IDLE the lookup follows the live CPU address; afterwards the captured
  // one, so the victim tag stays visible for the whole write-back.
  assign lookup_idx = (state_q == ST_IDLE) ? cpu_idx : req_idx;
  assign hit        = tag_valid && (tag_rd == cpu_tag);
  assign accept     = (state_q == ST_IDLE) && cpu_req;
  assign beat_ack   = req_on_q && mem_ack;
  assign last_ack   = beat_ack && (beat_q == LAST_BEAT);

  cache_dm_wb_burst_tag_array #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_tags (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (lookup_idx),
    .rd_valid (tag_valid),
    .rd_dirty (tag_dirty),
    .rd_tag   (tag_rd),
    .wr_en    (tag_wr_en),
    .wr_idx   (tag_wr_idx),
    .wr_tag   (tag_wr_tag),
    .wr_dirty (tag_wr_dirty)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    tag_wr_en    = 1'b0;
    tag_wr_idx   = req_idx;
    tag_wr_tag   = req_tag;
    tag_wr_dirty = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req && !hit) begin
          state_d = (tag_valid && tag_dirty) ? ST_WB : ST_FILL;
        end else if (cpu_req && cpu_we) begin
          tag_wr_en    = 1'b1;
          tag_wr_idx   = cpu_idx;
          tag_wr_tag   = cpu_tag;
          tag_wr_dirty = 1'b1;
        end
      end
      ST_WB: begin
        if (last_ack) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (last_ack) begin
          state_d   = ST_RESP;
          tag_wr_en = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (req_we_q) begin
          tag_wr_en    = 1'b1;
          tag_wr_dirty = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // single data-array write port: store hit, refill beat or store merge
  always_comb begin
    da_wr_en   = 1'b0;
    da_wr_addr = da_of(req_idx, req_word);
    da_wr_data = req_wdata_q;
    if (accept && hit && cpu_we) begin
      da_wr_en   = 1'b1;
      da_wr_addr = da_of(cpu_idx, cpu_word);
      da_wr_data = cpu_wdata;
    end else if ((state_q == ST_FILL) && beat_ack) begin
      da_wr_en   = 1'b1;
      da_wr_addr = da_of(req_idx, beat_q);
      da_wr_data = mem_rdata;
    end else if ((state_q == ST_RESP) && req_we_q) begin
      da_wr_en   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (da_wr_en && !reset) data_q[da_wr_addr] <= da_wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      beat_q      <= '0;
      req_on_q    <= 1'b0;
      cpu_rdata_q <= '0;
      cpu_done_q  <= 1'b0;
    end else begin
      cpu_done_q <= 1'b0;
      if (accept) begin
        req_we_q    <= cpu_we;
        req_addr_q  <= cpu_addr;
        req_wdata_q <= cpu_wdata;
        if (hit) begin
          cpu_done_q <= 1'b1;
          if (!cpu_we) cpu_rdata_q <= data_q[da_of(cpu_idx, cpu_word)];
        end
      end
      if (state_q == ST_RESP) begin
        cpu_done_q <= 1'b1;
        if (!req_we_q) cpu_rdata_q <= data_q[da_of(req_idx, req_word)];
      end
      if (beat_ack) beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
      // drop the request for one cycle after every ack, then re-raise it
      // while the next state is still a burst state
      req_on_q <= ((state_d == ST_WB) || (state_d == ST_FILL)) && !beat_ack;
    end
  end

  assign in_burst  = (state_q == ST_WB) || (state_q == ST_FILL);
  assign beat_tag  = (state_q == ST_WB) ? tag_rd : req_tag;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_done  = cpu_done_q;
  assign cpu_busy  = (state_q != ST_IDLE);
  assign mem_req   = req_on_q;
  assign mem_we    = (state_q == ST_WB);
  assign mem_addr  = in_burst ? ({beat_tag, req_idx, {OFF_W{1'b0}}} | (ADDR_W'(beat_q) << 2))
                              : '0;
  assign mem_wdata = (state_q == ST_WB) ? data_q[da_of(req_idx, beat_q)] : '0;

endmodule

// File: tb/tb_cache_dm_wb_burst.sv
module tb_cache_dm_wb_burst;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_done, cpu_busy;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_dm_wb_burst #(.SIZE_BYTES(8192), .LINE_WORDS(4), .ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_done  (cpu_done),
    .cpu_busy  (cpu_busy),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  // memory model: fixed wait before ack, default contents addr^A5A5_0000,
  // write-back beats are remembered
  int          mem_wait = 2;
  int          wait_cnt = 0;
  bit          wr_valid [16384];
  logic [31:0] wr_data  [16384];
  logic        prev_ack = 1'b0;
  int          gap_viol = 0;
  logic [31:0] beat_addr_q[$];
  logic        beat_we_q[$];
  logic [31:0] beat_data_q[$];

  assign mem_ack   = mem_req && (wait_cnt == mem_wait);
  assign mem_rdata = !mem_ack ? 32'h0 :
                     wr_valid[mem_addr[15:2]] ? wr_data[mem_addr[15:2]] :
                     (mem_addr ^ 32'hA5A5_0000);

  always @(posedge clk) begin
    wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;
    if (prev_ack && mem_req) gap_viol = gap_viol + 1;
    prev_ack <= mem_req && mem_ack;
    if (mem_req && mem_ack) begin
      beat_addr_q.push_back(mem_addr);
      beat_we_q.push_back(mem_we);
      beat_data_q.push_back(mem_wdata);
      if (mem_we) begin
        wr_valid[mem_addr[15:2]] <= 1'b1;
        wr_data[mem_addr[15:2]]  <= mem_wdata;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rdata"}, cpu_rdata, 32'h0);
    check({tag, "_done"},  {31'h0, cpu_done}, 32'h0);
    check({tag, "_busy"},  {31'h0, cpu_busy}, 32'h0);
    check({tag, "_mreq"},  {31'h0, mem_req}, 32'h0);
    check({tag, "_mwe"},   {31'h0, mem_we}, 32'h0);
    check({tag, "_maddr"}, mem_addr, 32'h0);
    check({tag, "_mwdata"}, mem_wdata, 32'h0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          wb_n;
    logic [31:0] wb_base;
    int          fill_n;
    logic [31:0] fill_base;
    logic [31:0] mark_addr;   // write-back word that differs from memory
    logic [31:0] mark_data;
    int          wait_cycles;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input int wb_n, input logic [31:0] wb_base,
                              input int fill_n, input logic [31:0] fill_base,
                              input logic [31:0] mark_addr, input logic [31:0] mark_data,
                              input int wait_cycles);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata;
    v.wb_n = wb_n; v.wb_base = wb_base; v.fill_n = fill_n; v.fill_base = fill_base;
    v.mark_addr = mark_addr; v.mark_data = mark_data; v.wait_cycles = wait_cycles;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int n);
    int          cycles;
    int          nwb;
    int          nfill;
    logic        order_bad;
    logic [31:0] exp_a;
    logic [31:0] exp_d;
    @(negedge clk);
    mem_wait = v.wait_cycles;
    beat_addr_q.delete();
    beat_we_q.delete();
    beat_data_q.delete();
    cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_wdata = 32'h0;
    cycles = 1;
    while (!cpu_done && cycles < 300) begin
      @(negedge clk);
      cycles++;
    end
    check($sformatf("v%0d_done", n), {31'h0, cpu_done}, 32'h1);
    check($sformatf("v%0d_busy", n), {31'h0, cpu_busy}, 32'h0);
    if (!v.we) check($sformatf("v%0d_rdata", n), cpu_rdata, v.exp_rdata);
    if (v.wb_n == 0 && v.fill_n == 0) check($sformatf("v%0d_hit_latency", n), cycles, 32'd1);
    nwb = 0; nfill = 0; order_bad = 1'b0;
    foreach (beat_addr_q[j]) begin
      if (beat_we_q[j]) begin
        if (nfill != 0) order_bad = 1'b1;
        exp_a = v.wb_base + 32'(4 * nwb);
        exp_d = (exp_a == v.mark_addr) ? v.mark_data : (exp_a ^ 32'hA5A5_0000);
        check($sformatf("v%0d_wb%0d_addr", n, nwb), beat_addr_q[j], exp_a);
        check($sformatf("v%0d_wb%0d_data", n, nwb), beat_data_q[j], exp_d);
        nwb++;
      end else begin
        exp_a = v.fill_base + 32'(4 * nfill);
        check($sformatf("v%0d_fill%0d_addr", n, nfill), beat_addr_q[j], exp_a);
        nfill++;
      end
    end
    check($sformatf("v%0d_wb_beats", n), nwb, v.wb_n);
    check($sformatf("v%0d_fill_beats", n), nfill, v.fill_n);
    check($sformatf("v%0d_beat_order", n), {31'h0, order_bad}, 32'h0);
    @(negedge clk);
    check($sformatf("v%0d_done_single", n), {31'h0, cpu_done}, 32'h0);
  endtask

  // dirty line 0x100 is evicted by a load of 0x2100; reset lands on beat 2
  task automatic reset_mid_wb();
    int   cycles;
    int   done_seen;
    int   req_seen;
    logic found;
    @(negedge clk);
    mem_wait = 2;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_2100; cpu_wdata = 32'h0;
    @(negedge clk);
    cpu_req = 1'b0;
    cycles = 0;
    found = mem_req && mem_we && (mem_addr == 32'h0000_0104);
    while (!found && cycles < 200) begin
      @(negedge clk);
      cycles++;
      found = mem_req && mem_we && (mem_addr == 32'h0000_0104);
    end
    check("rst_reach_wb_beat2", {31'h0, found}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_outputs_zero("rst_mid");
    done_seen = 0; req_seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (cpu_done) done_seen++;
      if (mem_req) req_seen++;
    end
    check("rst_no_done", done_seen, 32'd0);
    check("rst_no_mreq", req_seen, 32'd0);
  endtask

  vec_t vecs[12];

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    vecs[0]  = mk(0, 32'h0040, 0, 32'hA5A5_0040, 0, 0, 4, 32'h0040, 32'hFFFF_FFFF, 0, 2);
    vecs[1]  = mk(0, 32'h0044, 0, 32'hA5A5_0044, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 2);
    vecs[2]  = mk(1, 32'h0048, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 2);
    vecs[3]  = mk(0, 32'h2048, 0, 32'hA5A5_2048, 4, 32'h0040, 4, 32'h2040, 32'h0048, 32'hDEAD_BEEF, 2);
    vecs[4]  = mk(1, 32'h0100, 32'h1234_5678, 0, 0, 0, 4, 32'h0100, 32'hFFFF_FFFF, 0, 2);
    vecs[5]  = mk(0, 32'h0100, 0, 32'h1234_5678, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 2);
    // after the mid-burst reset: all lines invalid, memory holds earlier write-backs
    vecs[6]  = mk(0, 32'h0048, 0, 32'hDEAD_BEEF, 0, 0, 4, 32'h0040, 32'hFFFF_FFFF, 0, 2);
    vecs[7]  = mk(0, 32'h4048, 0, 32'hA5A5_4048, 0, 0, 4, 32'h4040, 32'hFFFF_FFFF, 0, 0);
    vecs[8]  = mk(1, 32'h4044, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0);
    vecs[9]  = mk(0, 32'h0044, 0, 32'hA5A5_0044, 4, 32'h4040, 4, 32'h0040, 32'h4044, 32'hCAFE_F00D, 0);
    vecs[10] = mk(0, 32'h0100, 0, 32'h1234_5678, 0, 0, 4, 32'h0100, 32'hFFFF_FFFF, 0, 0);
    vecs[11] = mk(0, 32'h0104, 0, 32'hA5A5_0104, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0);

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      if (i == 6) reset_mid_wb();
      run_vec(vecs[i], i);
    end

    check("mem_req_gap_after_ack", gap_viol, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
